key_matrix_scan: RTL and testbench
==================================

Name: key_matrix_scan

Overview:
Scanner for a passive ROWS x COLS push-button matrix. It drives one row low at a time, reads the column lines and debounces every key over whole scan frames. It reports each debounced key state as a vector and emits press/release events one at a time. It is the input-side counterpart to the LED matrix row/col driver: it drives rows and reads columns instead of driving both. It feeds game logic with key events in place of discrete buttons.

Parameters:
ROWS, 6, number of matrix rows driven
COLS, 6, number of matrix columns sensed
SCAN_DIV, 1200, clk cycles each row is held driven (100 us at 12 MHz); must be >= 8
DEBOUNCE_SCANS, 4, consecutive frames a key must disagree with its debounced state before that state flips; range 1..15
KW, $clog2(ROWS*COLS), key index width (6 for 6x6)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
row_drive  out  ROWS  active-low one-hot row strobe; all ones = no row driven
col_sense  in  COLS  raw column inputs, active-low (pulled up), asynchronous
keys  out  ROWS*COLS  debounced key state, bit index = row*COLS+col, 1 = pressed
key_event  out  1  one-cycle strobe: key_code/key_pressed valid
key_code  out  KW  index of the changed key
key_pressed  out  1  1 = press, 0 = release
frame_done  out  1  one-cycle pulse after the last row of each frame has been sampled

Behaviour:
- Reset (rst=1 on a clk edge): row_drive=all ones; keys=0; key_event=0; key_code=0; key_pressed=0; frame_done=0; row counter, divider, debounce counters, raw frame and pending mask all cleared.
- Reset mid-frame or with pending events: the frame is aborted, pending events are discarded and none are emitted.
- col_sense passes through a 2-flop synchronizer before use.
- Scan timing:
  - First cycle after reset release: row_drive = ~(1<<0).
  - Each row is driven for exactly SCAN_DIV cycles.
  - On the last cycle of a row period, the synchronized, inverted col_sense is stored into raw[row*COLS +: COLS].
  - row_drive then advances to the next row; row ROWS-1 wraps to row 0 with no gap.
  - Frame length = ROWS*SCAN_DIV cycles.
- Frame end: the cycle after row ROWS-1 is sampled is the update cycle. In that cycle frame_done=1 and, for every key i:
  - raw[i]==keys[i]: cnt[i] <= 0.
  - raw[i]!=keys[i] and cnt[i]==DEBOUNCE_SCANS-1: keys[i] toggles, cnt[i] <= 0, pend[i] <= 1.
  - Otherwise: cnt[i] increments.
- Event emitter:
  - Starting the cycle after the update cycle, each cycle it takes the lowest set bit j of pend.
  - It drives key_event=1, key_code=j, key_pressed=keys[j], and clears pend[j].
  - Events are therefore emitted in ascending index order on consecutive cycles.
  - key_code and key_pressed hold their last values when key_event=0.
- Because SCAN_DIV >= 8 and ROWS*SCAN_DIV > ROWS*COLS, pend always drains before the next update cycle. No event is ever lost or merged.
- No ghosting or anti-masking correction: a phantom key appears in raw and is debounced like any other key.
- A key changed in the update cycle appears in keys in the same cycle that frame_done is high, before its key_event.

Test Plan:
(All use SCAN_DIV=8, DEBOUNCE_SCANS=3, ROWS=COLS=6.)
1. Hold rst 3 cycles, then release -> row_drive=6'b111111 during reset; 6'b111110 for the first 8 cycles after release; then 6'b111101, and so on. Row 5 wraps to row 0 after 48 cycles. frame_done pulses once every 48 cycles.
2. Press row 2 col 3 (col_sense[3]=0 while row_drive[2]=0) and hold -> keys[15]=1 at the third frame's update cycle; exactly one key_event the next cycle with key_code=15, key_pressed=1. Release and hold released -> after 3 frames, one key_event with key_code=15, key_pressed=0.
3. Bounce: press key 15 for 2 frames, release for 1, press again -> no event until 3 consecutive pressed frames are observed after the re-press.
4. Keys 0 and 35 pressed in the same frame -> after 3 frames, key_event on two consecutive cycles: key_code 0 then 35, both key_pressed=1.
5. Key 7 debounce in progress (2 frames counted) and key 20 pending emission, then assert rst for 1 cycle -> no key_event is emitted; keys=0; scanning restarts at row 0.

Source files
------------

// File: rtl/key_matrix_scan.sv
// key_matrix_scan: scans a ROWS x COLS push-button matrix one row at a time.
// Each key is debounced over whole scan frames. The debounced state is
// published as a vector, and each press or release is reported as an event,
// one event per cycle.
module key_matrix_scan #(
  parameter int ROWS           = 6,
  parameter int COLS           = 6,
  parameter int SCAN_DIV       = 1200,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int KW             = $clog2(ROWS*COLS)
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [ROWS-1:0]      row_drive,
  input  logic [COLS-1:0]      col_sense,
  output logic [ROWS*COLS-1:0] keys,
  output logic                 key_event,
  output logic [KW-1:0]        key_code,
  output logic                 key_pressed,
  output logic                 frame_done
);

  localparam int NK = ROWS * COLS;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = 4;

  logic [COLS-1:0] r_col_s1, r_col_s2;
  logic            r_run;
  logic [RW-1:0]   r_row;
  logic [DW-1:0]   r_div;
  logic [ROWS-1:0] r_row_drive;
  logic [NK-1:0]   r_raw, r_keys, r_pend;
  logic [CW-1:0]   r_cnt [NK];
  logic            r_frame_done, r_key_event, r_key_pressed;
  logic [KW-1:0]   r_key_code;

  logic            w_row_last, w_sample, w_frame_last;
  logic [RW-1:0]   w_row_next;
  logic [NK-1:0]   w_raw_next, w_keys_next, w_pend_set, w_pend_next, w_clr;
  logic [CW-1:0]   w_cnt_next [NK];
  logic            w_pick;
  logic [KW-1:0]   w_pick_idx;

  assign row_drive   = r_row_drive;
  assign keys        = r_keys;
  assign key_event   = r_key_event;
  assign key_code    = r_key_code;
  assign key_pressed = r_key_pressed;
  assign frame_done  = r_frame_done;

  // Two-flop synchronizer for the asynchronous column lines (idle = pulled high).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_col_s1 <= '1;
      r_col_s2 <= '1;
    end else begin
      r_col_s1 <= col_sense;
      r_col_s2 <= r_col_s1;
    end
  end

  assign w_row_last   = (r_div == DW'(SCAN_DIV - 1));
  assign w_sample     = r_run && w_row_last;
  assign w_frame_last = w_sample && (r_row == RW'(ROWS - 1));
  assign w_row_next   = (r_row == RW'(ROWS - 1)) ? '0 : r_row + RW'(1);

  // Row strobe and divider: r_run marks that row 0 has started after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_run       <= 1'b0;
      r_row       <= '0;
      r_div       <= '0;
      r_row_drive <= '1;
    end else if (!r_run) begin
      r_run       <= 1'b1;
      r_row       <= '0;
      r_div       <= '0;
      r_row_drive <= ~(ROWS'(1));
    end else if (w_row_last) begin
      r_div       <= '0;
      r_row       <= w_row_next;
      r_row_drive <= ~(ROWS'(1) << w_row_next);
    end else begin
      r_div       <= r_div + DW'(1);
    end
  end

  // Raw frame: the current row's inverted columns replace its slot at the end of the row period.
  always_comb begin
    w_raw_next = r_raw;
    for (int r = 0; r < ROWS; r++) begin
      w_raw_next[r*COLS +: COLS] = (w_sample && (r_row == RW'(r))) ? ~r_col_s2
                                                                   : r_raw[r*COLS +: COLS];
    end
  end

  // Frame-end debounce: a key flips after DEBOUNCE_SCANS consecutive disagreeing frames.
  always_comb begin
    w_keys_next = r_keys;
    w_pend_set  = '0;
    for (int i = 0; i < NK; i++) begin
      w_cnt_next[i] = r_cnt[i];
      if (!w_frame_last) begin
        w_cnt_next[i] = r_cnt[i];
      end else if (w_raw_next[i] == r_keys[i]) begin
        w_cnt_next[i] = '0;
      end else if (r_cnt[i] == CW'(DEBOUNCE_SCANS - 1)) begin
        w_keys_next[i] = ~r_keys[i];
        w_cnt_next[i]  = '0;
        w_pend_set[i]  = 1'b1;
      end else begin
        w_cnt_next[i] = r_cnt[i] + CW'(1);
      end
    end
  end

  // Emitter selection: the lowest pending key index goes out first.
  always_comb begin
    w_pick     = |r_pend;
    w_pick_idx = '0;
    for (int i = NK - 1; i >= 0; i--) begin
      w_pick_idx = r_pend[i] ? KW'(i) : w_pick_idx;
    end
    w_clr       = w_pick ? (NK'(1) << w_pick_idx) : '0;
    w_pend_next = (r_pend & ~w_clr) | w_pend_set;
  end

  // Debounce state, raw frame and pending mask registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_raw        <= '0;
      r_keys       <= '0;
      r_pend       <= '0;
      r_frame_done <= 1'b0;
      for (int i = 0; i < NK; i++) r_cnt[i] <= '0;
    end else begin
      r_raw        <= w_raw_next;
      r_keys       <= w_keys_next;
      r_pend       <= w_pend_next;
      r_frame_done <= w_frame_last;
      r_cnt        <= w_cnt_next;
    end
  end

  // Event outputs: key_code/key_pressed hold their last values between events.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_key_event   <= 1'b0;
      r_key_code    <= '0;
      r_key_pressed <= 1'b0;
    end else begin
      r_key_event <= w_pick;
      if (w_pick) begin
        r_key_code    <= w_pick_idx;
        r_key_pressed <= r_keys[w_pick_idx];
      end
    end
  end

endmodule

// File: tb/tb_key_matrix_scan.sv
// Self-checking bench for key_matrix_scan. Each frame's pressed set is fed
// through a simulated switch matrix. A frame-level model predicts row
// timing, debounced keys and the ordered event stream.
module tb_key_matrix_scan;
  localparam int ROWS = 6, COLS = 6, SCAN_DIV = 8, DEB = 3;
  localparam int NK = ROWS * COLS, KW = 6, FRAME = ROWS * SCAN_DIV;

  logic            clk, rst;
  logic [ROWS-1:0] row_drive;
  logic [COLS-1:0] col_sense;
  logic [NK-1:0]   keys;
  logic            key_event, key_pressed, frame_done;
  logic [KW-1:0]   key_code;

  key_matrix_scan #(.ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV),
                    .DEBOUNCE_SCANS(DEB), .KW(KW)) dut (
    .clk(clk), .rst(rst), .row_drive(row_drive), .col_sense(col_sense),
    .keys(keys), .key_event(key_event), .key_code(key_code),
    .key_pressed(key_pressed), .frame_done(frame_done));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Physical matrix: a pressed key pulls its column low while its row is driven.
  logic [NK-1:0] pressed;
  always_comb begin
    col_sense = '1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (!row_drive[r] && pressed[r*COLS+c]) col_sense[c] = 1'b0;
  end

  int n_checks = 0, n_errors = 0;
  int k;
  logic [NK-1:0] m_keys, active;
  int            m_run [NK];
  logic [6:0]    exp_q [$];
  logic [KW-1:0] m_code;
  logic          m_pressed;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_keys = '0; m_code = '0; m_pressed = 1'b0; exp_q.delete();
    for (int i = 0; i < NK; i++) m_run[i] = 0;
  endtask

  // End of a frame: count consecutive frames a key differs from its state.
  task automatic apply_frame();
    for (int i = 0; i < NK; i++) begin
      if (active[i] != m_keys[i]) begin
        m_run[i]++;
        if (m_run[i] == DEB) begin
          m_keys[i] = ~m_keys[i];
          m_run[i]  = 0;
          exp_q.push_back({m_keys[i], 6'(i)});
        end
      end else begin
        m_run[i] = 0;
      end
    end
  endtask

  task automatic cycle_check();
    logic [6:0]      e;
    logic [ROWS-1:0] one, exp_row;
    @(posedge clk); @(negedge clk); k++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      m_code = e[5:0]; m_pressed = e[6];
      check_eq("key_event", 64'(key_event), 64'(1'b1));
    end else begin
      check_eq("key_event_idle", 64'(key_event), 64'(1'b0));
    end
    check_eq("key_code", 64'(key_code), 64'(m_code));
    check_eq("key_pressed", 64'(key_pressed), 64'(m_pressed));
    if (k % FRAME == 0) begin
      if (k > 0) apply_frame();
      active = pressed;
    end
    check_eq("frame_done", 64'(frame_done), 64'(k > 0 && (k % FRAME) == 0));
    check_eq("keys", 64'(keys), 64'(m_keys));
    one = 6'b000001;
    exp_row = ~(one << ((k / SCAN_DIV) % ROWS));
    check_eq("row_drive", 64'(row_drive), 64'(exp_row));
  endtask

  task automatic run_frames(input logic [NK-1:0] set, input int n);
    pressed = set;
    repeat (n * FRAME) cycle_check();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) begin
      @(posedge clk); @(negedge clk);
      check_eq("rst_row_drive", 64'(row_drive), 64'(6'b111111));
      check_eq("rst_keys", 64'(keys), 64'd0);
      check_eq("rst_key_event", 64'(key_event), 64'd0);
      check_eq("rst_key_code", 64'(key_code), 64'd0);
      check_eq("rst_frame_done", 64'(frame_done), 64'd0);
    end
    rst = 1'b0;
    model_clear();
    k = -1;
  endtask

  function automatic logic [NK-1:0] bit_of(input int i);
    logic [NK-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  initial begin
    logic [63:0]   r64;
    logic [NK-1:0] key7, key20;
    rst = 1'b1; pressed = '0; k = -1;
    model_clear();
    @(negedge clk);
    do_reset(3);
    // Idle scanning: row order, wrap and frame_done period.
    run_frames('0, 2);
    // Press and release key 15 (row 2, col 3).
    run_frames(bit_of(15), 4);
    run_frames('0, 4);
    // Bounce: 2 pressed, 1 released, then a full re-press.
    run_frames(bit_of(15), 2);
    run_frames('0, 1);
    run_frames(bit_of(15), 4);
    run_frames('0, 4);
    // Two corner keys in the same frame: events 0 then 35.
    run_frames(bit_of(0) | bit_of(35), 4);
    run_frames('0, 4);
    // Random pressed sets, each held for 1..4 frames.
    for (int s = 0; s < 12; s++) begin
      r64 = {$urandom(), $urandom()};
      run_frames(r64[NK-1:0], int'($urandom_range(1, 4)));
    end
    run_frames('0, 4);
    // Reset while key 7 is mid-debounce and key 20 is pending emission.
    key7 = bit_of(7); key20 = bit_of(20);
    run_frames(key20, 1);
    run_frames(key20 | key7, 2);
    cycle_check();
    do_reset(1);
    run_frames(key7, 4);
    run_frames('0, 4);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
